uart_rx: RTL and testbench
==========================

# uart_rx

Standalone UART receiver for the USB-UART debug link. It samples the line driven by the host bridge (usb_uart_txd_i at top level), recovers 8N1 (optionally 8E1) frames with 16x oversampling, and queues bytes in a small FIFO drained through a valid/ready handshake. It is the receive counterpart of the top-level UART transmit path and feeds debug or command logic in the sys_clk domain.

## Interface
- CLK_HZ, 250000000, sys_clk frequency in Hz
- BAUD, 115200, line rate
- FIFO_DEPTH, 8, byte FIFO entries, power of two, at least 2
- sys_clk_i  input  1  system clock; all logic is on its rising edge
- areset_n_i  input  1  reset, asynchronous assert, active-low
- rxd_i  input  1  asynchronous serial line, idle high
- data_o  output  8  FIFO head byte
- valid_o  output  1  FIFO not empty
- ready_i  input  1  consumer pops the head when valid_o && ready_i
- frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low
- parity_err_o  output  1  one-cycle pulse on parity mismatch
- overrun_o  output  1  one-cycle pulse when a byte is dropped because the FIFO is full
- busy_o  output  1  high whenever the FSM is not IDLE

## Operation
- rxd_i passes through a 2-FF synchronizer that resets to 1. All references to the line below mean the synchronized value.
- Tick generator: a counter wraps at DIV = CLK_HZ/(BAUD*16), rounded down, and produces a one-cycle tick. DIV < 1 is an elaboration error. The counter reloads to 0 on the start edge.
- Bit sampling: tick counter 0..15 per bit. Each bit value is the majority of the samples at ticks 7, 8 and 9. The bit is resolved at tick 9.
- FSM states:
  - IDLE: a 1->0 edge enters START.
  - START: at resolve, a 1 returns to IDLE as a false start and raises no flags. A 0 goes to DATA.
  - DATA: 8 bits, LSB first, into a shift register. After bit 7, go to PARITY if enabled, otherwise STOP.
  - PARITY: even parity check, then STOP.
  - STOP: if the stop bit is 1, push the byte and go to IDLE. If it is 0, pulse frame_err_o, discard the byte, and go to BREAK.
  - BREAK: wait until the line is 1, then go to IDLE.
- A parity mismatch pulses parity_err_o at stop resolve, and the byte is still pushed if the stop bit is good.
- FIFO, full case: a push with no pop in the same cycle drops the byte and pulses overrun_o. A push with a pop in the same cycle is accepted.
- FIFO, empty case: no pop is possible. A push makes valid_o high on the next cycle.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full means the MSBs differ and the rest of the bits are equal.
- Reset mid-frame: everything returns to reset state immediately, the FIFO is emptied, and a partial frame is lost. After release the FSM waits in IDLE for a fresh falling edge. A line held low through release does not start a frame.

## Timing
- Reset values:
  - data_o = 0
  - valid_o = 0
  - frame_err_o, parity_err_o, overrun_o = 0
  - busy_o = 0
  - FSM = IDLE, synchronizer = 11
- Latency: the byte is visible on data_o/valid_o 1 cycle after the stop-bit resolve cycle. The line edge is seen 2 cycles after rxd_i changes.
- data_o is stable while valid_o && !ready_i.
- Error pulses are exactly 1 cycle and coincide with the stop-resolve cycle + 1.
- Back-to-back frames: the next start edge is accepted from the cycle IDLE is re-entered, which is mid-stop-bit. This gives a 7-tick margin against clock mismatch.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1 with the PARITY state active, and parity_err_o is live.
- UART_RX_PARITY_EN undefined: frame is 8N1, the PARITY state and checker are absent, and parity_err_o is tied to 0.

## Structure
- Package mexiko_uart_pkg holds:
  - the uart_rx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - OVERSAMPLE=16 and SAMPLE_TICK_{A,B,C}=7,8,9
  - a function computing DIV
- Sub-module uart_rx_fifo holds the synchronous FIFO with the push/pop/full/overrun logic, parameterized by FIFO_DEPTH.

## Test plan
All scenarios use CLK_HZ=7372800 and BAUD=115200, giving DIV=4 and 64 clocks per bit.
- Single frame 0xA5, 8N1 -> data_o=0xA5 and valid_o high 1 cycle after stop resolve. With ready_i=1, valid_o drops on the next cycle. No error pulses.
- 10 back-to-back frames 0x00..0x09 with ready_i=0 and FIFO_DEPTH=8 -> bytes 0x00..0x07 are held. overrun_o pulses twice. Draining yields 0x00..0x07 in order.
- Stop bit forced low on byte 0x3C -> frame_err_o pulses once, nothing is pushed, and busy_o stays high until the line returns high.
- 20-clock low glitch while idle -> false start, returns to IDLE, no push, no flags.
- Single-sample glitch inside bit 3 of 0xFF -> majority vote still yields 0xFF.
- With UART_RX_PARITY_EN, send 0x01 with parity bit 0 -> parity_err_o pulses and 0x01 is still pushed. Assert areset_n_i low mid-frame -> valid_o=0, busy_o=0, and the next clean frame 0x55 is received correctly.

Source files
------------

// File: rtl/mexiko_uart_pkg.sv
// Shared types and constants for the debug-link UART receiver.
package mexiko_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_e;

  localparam int OVERSAMPLE    = 16;
  localparam int SAMPLE_TICK_A = 7;
  localparam int SAMPLE_TICK_B = 8;
  localparam int SAMPLE_TICK_C = 9;

  // floor(clk/(baud*16)); dividing in two steps gives the same floor and cannot overflow
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz / baud) / OVERSAMPLE;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the receiver: drops on full unless the same cycle pops.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       sys_clk_i,
  input  logic       areset_n_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       valid_o,
  output logic       overrun_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [AW:0]                  wr_ptr, rd_ptr;
  logic [FIFO_DEPTH-1:0][7:0]   mem;
  logic                         full, empty, do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem       <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata_i;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      overrun_o <= push_i && full && !do_pop;
    end
  end

  assign rdata_o = mem[rd_ptr[AW-1:0]];
  assign valid_o = !empty;
endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver with byte FIFO and valid/ready drain.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err_o.
module uart_rx
  import mexiko_uart_pkg::*;
#(
  parameter int CLK_HZ     = 250000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       sys_clk_i,
  input  logic       areset_n_i,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);
  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx: CLK_HZ too low for 16x oversampling at BAUD");
  end

  logic           rx_meta, rx_sync, rx_prev;
  logic [1:0]     fill;
  logic [DW-1:0]  div_cnt;
  logic           tick, start_edge, resolve, maj, push;
  uart_rx_state_e state;
  logic [3:0]     os_cnt;
  logic [1:0]     smp;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  // rx_prev only trusts the synchronizer once real line values have filled it,
  // so a line held low through reset release never looks like a start edge.
  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b0;
      fill    <= 2'b00;
    end else begin
      rx_meta <= rxd_i;
      rx_sync <= rx_meta;
      fill    <= {fill[0], 1'b1};
      rx_prev <= fill[1] & rx_sync;
    end
  end

  assign start_edge = (state == IDLE) && rx_prev && !rx_sync;
  assign tick       = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i)             div_cnt <= '0;
    else if (start_edge || tick) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 1'b1;
  end

  assign resolve = tick && (os_cnt == 4'(SAMPLE_TICK_C));
  assign maj     = (smp[0] & smp[1]) | (smp[0] & rx_sync) | (smp[1] & rx_sync);
  assign push    = (state == STOP) && resolve && maj;
  assign busy_o  = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif

  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state       <= IDLE;
      os_cnt      <= '0;
      smp         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
      par_bad      <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      if (tick && state != IDLE && state != BREAK) begin
        os_cnt <= os_cnt + 4'd1;
        if (os_cnt == 4'(SAMPLE_TICK_A)) smp[0] <= rx_sync;
        if (os_cnt == 4'(SAMPLE_TICK_B)) smp[1] <= rx_sync;
      end
      case (state)
        IDLE: if (start_edge) begin
          state  <= START;
          os_cnt <= '0;
        end
        START: if (resolve) begin
          state   <= maj ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA: if (resolve) begin
          shreg   <= {maj, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (resolve) begin
          par_bad <= maj ^ (^shreg);
          state   <= STOP;
        end
`endif
        STOP: if (resolve) begin
`ifdef UART_RX_PARITY_EN
          parity_err_o <= par_bad;
`endif
          if (maj) state <= IDLE;
          else begin
            frame_err_o <= 1'b1;
            state       <= BREAK;
          end
        end
        BREAK: if (rx_sync) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

  uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk_i (sys_clk_i),
    .areset_n_i(areset_n_i),
    .push_i    (push),
    .wdata_i   (shreg),
    .pop_i     (ready_i),
    .rdata_o   (data_o),
    .valid_o   (valid_o),
    .overrun_o (overrun_o)
  );
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx at DIV=4 (64 clocks per bit).
module tb_uart_rx;
  localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, ready = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, perr, ovr, busy;

  uart_rx #(.CLK_HZ(7372800), .BAUD(115200), .FIFO_DEPTH(8)) dut (
    .sys_clk_i(clk), .areset_n_i(rst_n), .rxd_i(rxd), .data_o(data), .valid_o(valid),
    .ready_i(ready), .frame_err_o(ferr), .parity_err_o(perr), .overrun_o(ovr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int n_ferr = 0, n_perr = 0, n_ovr = 0, n_pop = 0, n_vcyc = 0, t_valid = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor: counts pulses, pops the scoreboard on each handshake.
  initial begin
    logic       hold_prev;
    logic [7:0] last_data;
    hold_prev = 1'b0;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (ferr)  n_ferr++;
      if (perr)  n_perr++;
      if (ovr)   n_ovr++;
      if (valid) n_vcyc++;
      if (valid && t_valid < 0) t_valid = cyc;
      if (hold_prev && valid) chk("data_stable", data, last_data);
      if (valid && ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pop actual=%0h required=none", data);
        end else chk("pop_data", data, exp_q.pop_front());
      end
      hold_prev = valid && !ready;
      last_data = data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR) send_bit((^d) ^ par_flip);
    send_bit(stop);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    chk(name, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       push;
    int         ferr;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   f0, p0, o0, v0, pop0, c0;
    tbl[0] = '{8'h00, 1'b1, 1'b1, 0};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 1};
    tbl[3] = '{8'h81, 1'b1, 1'b1, 0};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 0};

    tick(3);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_flags", {ferr, perr, ovr}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);

    // single frame latency: valid 619 edges after the start bit is driven
    ready = 1'b1;
    f0 = n_ferr; p0 = n_perr; o0 = n_ovr; v0 = n_vcyc;
    exp_q.push_back(8'hA5);
    t_valid = -1;
    c0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(20);
    chk("a5_latency", t_valid - c0, 619);
    chk("a5_valid_cycles", n_vcyc - v0, 1);
    chk("a5_flags", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
    drain("a5_drain");

    foreach (tbl[k]) begin
      f0 = n_ferr; p0 = n_perr; pop0 = n_pop;
      if (tbl[k].push) exp_q.push_back(tbl[k].d);
      send_frame(tbl[k].d, tbl[k].stop, 1'b0);
      if (!tbl[k].stop) begin
        tick(100);
        chk("break_busy", busy, 1);
        rxd = 1'b1;
        tick(10);
        chk("break_idle", busy, 0);
      end else tick(20);
      chk("tbl_ferr", n_ferr - f0, tbl[k].ferr);
      chk("tbl_perr", n_perr - p0, 0);
      chk("tbl_pops", n_pop - pop0, tbl[k].push ? 1 : 0);
      drain("tbl_drain");
    end

    // back-to-back frames into a full FIFO
    ready = 1'b0;
    o0 = n_ovr;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0);
    end
    tick(20);
    chk("ovr_count", n_ovr - o0, 2);
    chk("ovr_held", exp_q.size(), 8);
    chk("ovr_valid", valid, 1);
    ready = 1'b1;
    drain("ovr_drain");
    tick(2);
    chk("ovr_empty", valid, 0);

    // 20-clock low glitch is a false start
    f0 = n_ferr; p0 = n_perr; pop0 = n_pop;
    rxd = 1'b0;
    tick(20);
    rxd = 1'b1;
    tick(5);
    chk("glitch_busy", busy, 1);
    tick(60);
    chk("glitch_idle", busy, 0);
    chk("glitch_nopush", (n_pop - pop0) + (n_ferr - f0) + (n_perr - p0), 0);

    // one low sample inside data bit 3 of 0xFF is outvoted
    pop0 = n_pop;
    exp_q.push_back(8'hFF);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rxd = 1'b1; tick(36);
        rxd = 1'b0; tick(2);
        rxd = 1'b1; tick(26);
      end else send_bit(1'b1);
    end
    if (PAR) send_bit(1'b0);
    send_bit(1'b1);
    tick(20);
    chk("maj_pops", n_pop - pop0, 1);
    drain("maj_drain");

    if (PAR) begin
      p0 = n_perr;
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1, 1'b1);
      tick(20);
      chk("par_err", n_perr - p0, 1);
      drain("par_drain");
    end

    // reset mid-frame with a byte queued; line held low through release
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    tick(5);
    chk("mr_valid_before", valid, 1);
    rxd = 1'b0;
    tick(200);
    chk("mr_busy_before", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("mr_valid", valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_data", data, 0);
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    tick(150);
    chk("mr_low_release", busy, 0);
    rxd = 1'b1;
    tick(10);
    ready = 1'b1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    tick(20);
    drain("mr_55");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
